// File: rtl/wb_regfile_write_scheduler.sv
// Write-back scheduler: queues main/third bus results and retires them in order
// through the register file's single write port, with forwarding lookup.
`ifndef Def_RegisterSelectWidth
`define Def_RegisterSelectWidth 5
`endif
`ifndef WordWidth
`define WordWidth 32
`endif

module wb_regfile_write_scheduler #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_WBWriteEnable,
  input  logic                                in_MainWriteEnable,
  input  logic [`Def_RegisterSelectWidth-1:0] in_MainWriteRegister,
  input  logic [`WordWidth-1:0]               in_MainWriteResult,
  input  logic                                in_ThirdWriteEnable,
  input  logic [`Def_RegisterSelectWidth-1:0] in_ThirdWriteRegister,
  input  logic [`WordWidth-1:0]               in_ThirdWriteResult,
  input  logic                                in_RegFileReady,
  input  logic [`Def_RegisterSelectWidth-1:0] in_LookupRegister,
  output logic                                out_WBCanGo,
  output logic                                out_RegWriteEnable,
  output logic [`Def_RegisterSelectWidth-1:0] out_RegWriteNumber,
  output logic [`WordWidth-1:0]               out_RegWriteBus,
  output logic                                out_LookupHit,
  output logic [`WordWidth-1:0]               out_LookupData,
  output logic [PTR_W:0]                      out_Count
);

  localparam int CNT_W = PTR_W + 1;

  logic [`Def_RegisterSelectWidth-1:0] entryReg_q  [DEPTH];
  logic [`WordWidth-1:0]               entryData_q [DEPTH];
  logic [DEPTH-1:0]                    valid_q;
  logic [PTR_W-1:0]                    head_q, head_d, tail_q, tail_d, thirdSlot;
  logic [CNT_W-1:0]                    count_q, count_d;
  logic [`Def_RegisterSelectWidth-1:0] lastReg_q;
  logic [`WordWidth-1:0]               lastData_q;
  logic                                accept, pushMain, pushThird, pop;
  logic [PTR_W-1:0]                    idx;

  // Acceptance looks only at registered occupancy; a same-cycle pop earns no credit.
  always_comb begin
    out_WBCanGo = (count_q <= CNT_W'(DEPTH - 2));
    accept      = in_WBWriteEnable && out_WBCanGo;
    pushMain    = accept && in_MainWriteEnable;
    pushThird   = accept && in_ThirdWriteEnable;
    pop         = (count_q != '0) && in_RegFileReady;
    thirdSlot   = tail_q + PTR_W'(pushMain);
    tail_d      = tail_q + PTR_W'(pushMain) + PTR_W'(pushThird);
    head_d      = head_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(pushMain) + CNT_W'(pushThird) - CNT_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      lastReg_q  <= '0;
      lastData_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (count_q != '0) begin
        lastReg_q  <= entryReg_q[head_q];
        lastData_q <= entryData_q[head_q];
      end
      if (pop)       valid_q[head_q]    <= 1'b0;
      if (pushMain)  valid_q[tail_q]    <= 1'b1;
      if (pushThird) valid_q[thirdSlot] <= 1'b1;
    end
  end

  // Payload storage needs no reset: the valid bits and count gate every use of it.
  always_ff @(posedge clock) begin
    if (pushMain) begin
      entryReg_q[tail_q]  <= in_MainWriteRegister;
      entryData_q[tail_q] <= in_MainWriteResult;
    end
    if (pushThird) begin
      entryReg_q[thirdSlot]  <= in_ThirdWriteRegister;
      entryData_q[thirdSlot] <= in_ThirdWriteResult;
    end
  end

  always_comb begin
    out_RegWriteEnable = (count_q != '0);
    out_RegWriteNumber = out_RegWriteEnable ? entryReg_q[head_q]  : lastReg_q;
    out_RegWriteBus    = out_RegWriteEnable ? entryData_q[head_q] : lastData_q;
    out_Count          = count_q;
  end

  // Walk from oldest to youngest so the last match is the youngest write.
  always_comb begin
    out_LookupHit  = 1'b0;
    out_LookupData = '0;
    idx            = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (entryReg_q[idx] == in_LookupRegister)) begin
        out_LookupHit  = 1'b1;
        out_LookupData = entryData_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile_write_scheduler.sv
// Bench for wb_regfile_write_scheduler: directed stimulus feeds a scoreboard
// queue, a negedge monitor checks every retired register file write.
`ifndef Def_RegisterSelectWidth
`define Def_RegisterSelectWidth 5
`endif
`ifndef WordWidth
`define WordWidth 32
`endif

module tb_wb_regfile_write_scheduler;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic        clock;
  logic        reset;
  logic        in_WBWriteEnable;
  logic        in_MainWriteEnable;
  logic [4:0]  in_MainWriteRegister;
  logic [31:0] in_MainWriteResult;
  logic        in_ThirdWriteEnable;
  logic [4:0]  in_ThirdWriteRegister;
  logic [31:0] in_ThirdWriteResult;
  logic        in_RegFileReady;
  logic [4:0]  in_LookupRegister;
  logic        out_WBCanGo;
  logic        out_RegWriteEnable;
  logic [4:0]  out_RegWriteNumber;
  logic [31:0] out_RegWriteBus;
  logic        out_LookupHit;
  logic [31:0] out_LookupData;
  logic [2:0]  out_Count;

  wr_t expQ[$];
  int  modelCount;
  int  checks;
  int  errors;

  wb_regfile_write_scheduler #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .in_WBWriteEnable      (in_WBWriteEnable),
    .in_MainWriteEnable    (in_MainWriteEnable),
    .in_MainWriteRegister  (in_MainWriteRegister),
    .in_MainWriteResult    (in_MainWriteResult),
    .in_ThirdWriteEnable   (in_ThirdWriteEnable),
    .in_ThirdWriteRegister (in_ThirdWriteRegister),
    .in_ThirdWriteResult   (in_ThirdWriteResult),
    .in_RegFileReady       (in_RegFileReady),
    .in_LookupRegister     (in_LookupRegister),
    .out_WBCanGo           (out_WBCanGo),
    .out_RegWriteEnable    (out_RegWriteEnable),
    .out_RegWriteNumber    (out_RegWriteNumber),
    .out_RegWriteBus       (out_RegWriteBus),
    .out_LookupHit         (out_LookupHit),
    .out_LookupData        (out_LookupData),
    .out_Count             (out_Count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, records accepted writes, then advances past the edge.
  task automatic applyStimulus(input logic wbEn, input logic mEn, input logic [4:0] mReg,
                               input logic [31:0] mData, input logic tEn, input logic [4:0] tReg,
                               input logic [31:0] tData, input logic ready);
    int pushes;
    in_WBWriteEnable      = wbEn;
    in_MainWriteEnable    = mEn;
    in_MainWriteRegister  = mReg;
    in_MainWriteResult    = mData;
    in_ThirdWriteEnable   = tEn;
    in_ThirdWriteRegister = tReg;
    in_ThirdWriteResult   = tData;
    in_RegFileReady       = ready;
    pushes = 0;
    if (wbEn && modelCount <= DEPTH - 2) begin
      if (mEn) begin expQ.push_back('{r: mReg, d: mData}); pushes++; end
      if (tEn) begin expQ.push_back('{r: tReg, d: tData}); pushes++; end
    end
    modelCount = modelCount + pushes - ((modelCount != 0 && ready) ? 1 : 0);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic ready);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ready);
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b0;
    expQ.delete();
    modelCount = 0;
    in_WBWriteEnable   = 1'b1;
    in_MainWriteEnable = 1'b1;
    in_MainWriteRegister = 5'd1;
    in_MainWriteResult   = 32'hDEADBEEF;
    in_RegFileReady    = 1'b1;
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    in_WBWriteEnable   = 1'b0;
    in_MainWriteEnable = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int expCount, input logic expCanGo,
                             input logic [4:0] lookReg, input logic expHit, input logic [31:0] expData);
    in_LookupRegister = lookReg;
    #1;
    cmp({tag, "_count"}, 32'(out_Count), 32'(expCount));
    cmp({tag, "_cango"}, 32'(out_WBCanGo), 32'(expCanGo));
    cmp({tag, "_we"}, 32'(out_RegWriteEnable), 32'(expCount != 0));
    cmp({tag, "_hit"}, 32'(out_LookupHit), 32'(expHit));
    cmp({tag, "_ldata"}, out_LookupData, expData);
  endtask

  // Any write presented with nothing outstanding is a stale or phantom write.
  always @(negedge clock) begin
    if (reset && out_RegWriteEnable) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got R%0d=%h expected none", out_RegWriteNumber, out_RegWriteBus);
      end else if (in_RegFileReady) begin
        wr_t e;
        e = expQ.pop_front();
        cmp("retire_reg", 32'(out_RegWriteNumber), 32'(e.r));
        cmp("retire_data", out_RegWriteBus, e.d);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    modelCount = 0;
    in_LookupRegister     = 5'd0;
    in_MainWriteEnable    = 1'b0;
    in_ThirdWriteEnable   = 1'b0;
    in_ThirdWriteRegister = 5'd0;
    in_ThirdWriteResult   = 32'd0;
    doReset(2);

    checkOutput("reset", 0, 1'b1, 5'd1, 1'b0, 32'd0);
    cmp("reset_num", 32'(out_RegWriteNumber), 32'd0);
    cmp("reset_bus", out_RegWriteBus, 32'd0);
    idle(1'b1);
    idle(1'b1);

    applyStimulus(1'b1, 1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("single", 1, 1'b1, 5'd3, 1'b1, 32'h11111111);
    idle(1'b1);
    checkOutput("single_drain", 0, 1'b1, 5'd3, 1'b0, 32'd0);
    cmp("hold_num", 32'(out_RegWriteNumber), 32'd3);
    cmp("hold_bus", out_RegWriteBus, 32'h11111111);

    applyStimulus(1'b1, 1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB, 1'b0);
    checkOutput("dual", 2, 1'b1, 5'd5, 1'b1, 32'hB);
    idle(1'b1);
    checkOutput("dual_pop1", 1, 1'b1, 5'd5, 1'b1, 32'hB);
    idle(1'b1);
    checkOutput("dual_pop2", 0, 1'b1, 5'd5, 1'b0, 32'd0);

    applyStimulus(1'b1, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 1'b0);
    checkOutput("bp1", 2, 1'b1, 5'd10, 1'b1, 32'hA0);
    applyStimulus(1'b1, 1'b1, 5'd12, 32'hA1, 1'b1, 5'd13, 32'hB1, 1'b0);
    checkOutput("bp2", 4, 1'b0, 5'd13, 1'b1, 32'hB1);
    applyStimulus(1'b1, 1'b1, 5'd14, 32'hA2, 1'b1, 5'd15, 32'hB2, 1'b0);
    checkOutput("bp3", 4, 1'b0, 5'd14, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd16, 32'hA3, 1'b1, 5'd17, 32'hB3, 1'b0);
    checkOutput("bp4", 4, 1'b0, 5'd17, 1'b0, 32'd0);
    idle(1'b1);
    checkOutput("drain3", 3, 1'b0, 5'd10, 1'b0, 32'd0);
    idle(1'b1);
    checkOutput("drain2", 2, 1'b1, 5'd12, 1'b1, 32'hA1);
    idle(1'b1);
    idle(1'b1);
    checkOutput("drain0", 0, 1'b1, 5'd13, 1'b0, 32'd0);

    applyStimulus(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("three", 3, 1'b0, 5'd2, 1'b1, 32'h2);
    doReset(1);
    checkOutput("midreset", 0, 1'b1, 5'd3, 1'b0, 32'd0);
    cmp("midreset_num", 32'(out_RegWriteNumber), 32'd0);
    idle(1'b1);
    idle(1'b1);
    checkOutput("midreset_idle", 0, 1'b1, 5'd1, 1'b0, 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 5'(i), 32'h1000 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b1);
      checkOutput("wrap", 1, 1'b1, 5'(i), 1'b1, 32'h1000 + 32'(i));
    end
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1);
    checkOutput("third_only", 1, 1'b1, 5'd9, 1'b1, 32'h99);
    idle(1'b1);
    checkOutput("final", 0, 1'b1, 5'd9, 1'b0, 32'd0);
    idle(1'b1);
    cmp("queue_empty", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
